// File: rtl/adc_channel_averager.sv
// Boxcar averager for eight 12-bit ADC channels: coherent snapshot on a periodic tick,
// serial accumulation over 2**LOG2_AVG ticks, publish with valid strobe and hysteresis alarms.
module adc_channel_averager #(
    parameter int TICK_DIV = 16,
    parameter int LOG2_AVG = 2,
    parameter int HI_THR   = 3000,
    parameter int LO_THR   = 1000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [11:0] CH0,
    input  logic [11:0] CH1,
    input  logic [11:0] CH2,
    input  logic [11:0] CH3,
    input  logic [11:0] CH4,
    input  logic [11:0] CH5,
    input  logic [11:0] CH6,
    input  logic [11:0] CH7,
    output logic [11:0] AVG0,
    output logic [11:0] AVG1,
    output logic [11:0] AVG2,
    output logic [11:0] AVG3,
    output logic [11:0] AVG4,
    output logic [11:0] AVG5,
    output logic [11:0] AVG6,
    output logic [11:0] AVG7,
    output logic        AVG_VALID,
    output logic [7:0]  ALARM,
    output logic        BUSY
);

    localparam int TCW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ACC_W = 12 + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;

    localparam logic [TCW-1:0]   TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] WINDOW    = CNT_W'(2 ** LOG2_AVG);
    localparam logic [11:0]      HI_LVL    = 12'(HI_THR);
    localparam logic [11:0]      LO_LVL    = 12'(LO_THR);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [TCW-1:0]    tick_cnt_reg;
    logic [2:0]        idx_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_inc;
    logic              tick;
    logic              start_scan;
    logic              last_scan;
    logic              valid_reg;

    logic [11:0]       ch       [8];
    logic [11:0]       snap_reg [8];
    logic [ACC_W-1:0]  acc_reg  [8];
    logic [11:0]       avg_next [8];
    logic [11:0]       avg_reg  [8];
    logic [7:0]        alarm_reg;

    assign ch[0] = CH0;
    assign ch[1] = CH1;
    assign ch[2] = CH2;
    assign ch[3] = CH3;
    assign ch[4] = CH4;
    assign ch[5] = CH5;
    assign ch[6] = CH6;
    assign ch[7] = CH7;

    assign AVG0 = avg_reg[0];
    assign AVG1 = avg_reg[1];
    assign AVG2 = avg_reg[2];
    assign AVG3 = avg_reg[3];
    assign AVG4 = avg_reg[4];
    assign AVG5 = avg_reg[5];
    assign AVG6 = avg_reg[6];
    assign AVG7 = avg_reg[7];

    assign AVG_VALID = valid_reg;
    assign ALARM     = alarm_reg;
    assign BUSY      = (state_reg != IDLE);

    assign tick       = (tick_cnt_reg == TICK_LAST) && ENABLE;
    assign start_scan = (state_reg == IDLE) && tick;
    assign last_scan  = (state_reg == SCAN) && (idx_reg == 3'd7);
    assign count_inc  = count_reg + CNT_W'(1);

    // Tick generator parks at zero while disabled so the next tick is a full period away.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            tick_cnt_reg <= '0;
        end else if (!ENABLE || tick_cnt_reg == TICK_LAST) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TCW'(1);
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (tick) state_next = SCAN;
            SCAN:    if (idx_reg == 3'd7) state_next = (count_inc == WINDOW) ? PUBLISH : IDLE;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            idx_reg   <= '0;
            count_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            idx_reg   <= (state_reg == SCAN) ? idx_reg + 3'd1 : 3'd0;
            valid_reg <= (state_reg == PUBLISH);
            if (state_reg == PUBLISH) begin
                count_reg <= '0;
            end else if (last_scan) begin
                count_reg <= count_inc;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_chan
            assign avg_next[gi] = acc_reg[gi][ACC_W-1:LOG2_AVG];

            // One channel per SCAN cycle, always from the coherent snapshot.
            always_ff @(posedge CLOCK or posedge RESET) begin
                if (RESET) begin
                    snap_reg[gi] <= '0;
                    acc_reg[gi]  <= '0;
                end else begin
                    if (start_scan) begin
                        snap_reg[gi] <= ch[gi];
                    end
                    if (state_reg == PUBLISH) begin
                        acc_reg[gi] <= '0;
                    end else if (state_reg == SCAN && idx_reg == 3'(gi)) begin
                        acc_reg[gi] <= acc_reg[gi] + ACC_W'(snap_reg[gi]);
                    end
                end
            end

            always_ff @(posedge CLOCK or posedge RESET) begin
                if (RESET) begin
                    avg_reg[gi]   <= '0;
                    alarm_reg[gi] <= 1'b0;
                end else if (state_reg == PUBLISH) begin
                    avg_reg[gi] <= avg_next[gi];
                    if (avg_next[gi] >= HI_LVL) begin
                        alarm_reg[gi] <= 1'b1;
                    end else if (avg_next[gi] <= LO_LVL) begin
                        alarm_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule
